// File: rtl/conv_pkg.sv
// Shared sizes, address widths and FSM state type for the 112x49 valid-convolution engine.
package conv_pkg;

    localparam int unsigned N    = 112;
    localparam int unsigned M    = 49;
    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 26;
    localparam int unsigned PW   = 2 * XW;
    localparam int unsigned NOUT = N - M + 1;

    localparam int unsigned AW_X = $clog2(N);
    localparam int unsigned AW_F = $clog2(M);
    localparam int unsigned AW_Y = $clog2(NOUT);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

endpackage

// File: rtl/conv_mac.sv
// Signed XW x XW multiply feeding a YW-bit accumulator with synchronous clear.
module conv_mac
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [XW-1:0] i_a,
    input  logic [XW-1:0] i_b,
    output logic [YW-1:0] o_acc
);

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic        [YW-1:0] r_acc;

    // Full-precision product, sign-extended into the accumulator width.
    assign w_a    = PW'($signed(i_a));
    assign w_b    = PW'($signed(i_b));
    assign w_prod = w_a * w_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + YW'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_112_49.sv
// Streaming 1-D valid convolution: loads X (112) and F (49), emits 64 dot products in order.
// Optional build macro CONV_RELU_EN clamps negative results to zero at the output register.
module conv_112_49
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [XW-1:0] f_data,
    input  logic          f_valid,
    output logic          f_ready,
    output logic [YW-1:0] y_data,
    output logic          y_valid,
    input  logic          y_ready
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW_X-1:0] r_xcnt;
    logic [AW_X-1:0] w_xcnt_nxt;
    logic [AW_F-1:0] r_fcnt;
    logic [AW_F-1:0] w_fcnt_nxt;
    logic [AW_F-1:0] r_j;
    logic [AW_Y-1:0] r_m;

    logic            r_x_ready;
    logic            r_f_ready;
    logic            r_y_valid;
    logic [YW-1:0]   r_y_data;
    logic            w_x_ready_nxt;
    logic            w_f_ready_nxt;

    logic [XW-1:0]   r_x_mem [N];
    logic [XW-1:0]   r_f_mem [M];
    logic [XW-1:0]   r_xd;
    logic [XW-1:0]   r_fd;
    logic            r_pv;

    logic            w_x_take;
    logic            w_f_take;
    logic            w_issue;
    logic            w_done;
    logic            w_accept;
    logic            w_last;
    logic            w_clear;
    logic [AW_X-1:0] w_xaddr;
    logic [YW-1:0]   w_acc;
    logic [YW-1:0]   w_y_load;

    assign w_x_take   = r_x_ready & x_valid;
    assign w_f_take   = r_f_ready & f_valid;
    assign w_xcnt_nxt = r_xcnt + AW_X'(w_x_take);
    assign w_fcnt_nxt = r_fcnt + AW_F'(w_f_take);

    // r_j walks 0..M+1: reads issued for 0..M-1, one cycle to drain the read pipe, one to finish the MAC.
    assign w_issue  = (r_state == S_COMPUTE) && (r_j < AW_F'(M));
    assign w_done   = (r_state == S_COMPUTE) && (r_j == AW_F'(M + 1));
    assign w_clear  = (r_state == S_COMPUTE) && (r_j == '0);
    assign w_accept = r_y_valid & y_ready;
    assign w_last   = (r_m == AW_Y'(NOUT - 1));
    assign w_xaddr  = AW_X'(r_m) + AW_X'(r_j);

`ifdef CONV_RELU_EN
    assign w_y_load = w_acc[YW-1] ? '0 : w_acc;
`else
    assign w_y_load = w_acc;
`endif

    // Next-state and next-ready decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_x_ready_nxt = 1'b0;
        w_f_ready_nxt = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_x_ready_nxt = (w_xcnt_nxt != AW_X'(N));
                w_f_ready_nxt = (w_fcnt_nxt != AW_F'(M));
                if ((w_xcnt_nxt == AW_X'(N)) && (w_fcnt_nxt == AW_F'(M))) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_done) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt   = S_LOAD;
                        w_x_ready_nxt = 1'b1;
                        w_f_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_COMPUTE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_xcnt    <= '0;
            r_fcnt    <= '0;
            r_j       <= '0;
            r_m       <= '0;
            r_pv      <= 1'b0;
            r_x_ready <= 1'b0;
            r_f_ready <= 1'b0;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x_ready <= w_x_ready_nxt;
            r_f_ready <= w_f_ready_nxt;
            r_pv      <= w_issue;
            if ((r_state == S_OUTPUT) && (w_state_nxt == S_LOAD)) begin
                r_xcnt <= '0;
                r_fcnt <= '0;
            end else begin
                r_xcnt <= w_xcnt_nxt;
                r_fcnt <= w_fcnt_nxt;
            end
            r_j <= ((r_state == S_COMPUTE) && !w_done) ? r_j + AW_F'(1) : '0;
            if (w_accept) begin
                r_m <= w_last ? '0 : r_m + AW_Y'(1);
            end
            if (w_done) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_y_load;
            end else if (w_accept) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    // Sample memories and the read pipeline register; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_x_take) begin
            r_x_mem[r_xcnt] <= x_data;
        end
        if (w_f_take) begin
            r_f_mem[r_fcnt] <= f_data;
        end
        if (w_issue) begin
            r_xd <= r_x_mem[w_xaddr];
            r_fd <= r_f_mem[r_j];
        end
    end

    conv_mac u_mac (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_en    (r_pv),
        .i_a     (r_xd),
        .i_b     (r_fd),
        .o_acc   (w_acc)
    );

    assign x_ready = r_x_ready;
    assign f_ready = r_f_ready;
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;

endmodule

// File: tb/tb_conv_112_49.sv
// Directed bench for conv_112_49: two back-to-back sets, backpressure, idle, mid-load reset, signedness.
module tb_conv_112_49;

    localparam int LIMIT = 15000;

    logic        clk;
    logic        reset;
    logic [9:0]  x_data;
    logic        x_valid;
    logic        x_ready;
    logic [9:0]  f_data;
    logic        f_valid;
    logic        f_ready;
    logic [25:0] y_data;
    logic        y_valid;
    logic        y_ready;

    int checks;
    int errors;

    logic [25:0] cap [128];
    int          ncap;
    int          nstab;

    conv_112_49 dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .f_data  (f_data),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] xval(input int kind, input int i);
        case (kind)
            1:       return 10'(i - 128);
            2:       return 10'(i - 16);
            3:       return 10'(1);
            default: return 10'(-512);
        endcase
    endfunction

    function automatic logic [9:0] fval(input int kind, input int j);
        case (kind)
            1:       return 10'(j - 64);
            2:       return 10'(j - 15);
            3:       return 10'(-1);
            default: return 10'(-512);
        endcase
    endfunction

    function automatic logic [25:0] yexp(input int kind, input int m);
        case (kind)
            1:       return 26'(213640 - 1960 * m);
            2:       return 26'(13328 + 441 * m);
`ifdef CONV_RELU_EN
            3:       return 26'(0);
`else
            3:       return 26'(-49);
`endif
            default: return 26'(12845056);
        endcase
    endfunction

    task automatic drive_x(input int kind, input bit rnd, input int cnt);
        int i = 0;
        int cyc = 0;
        bit v;
        while (i < cnt && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            x_valid = v;
            x_data  = v ? xval(kind, i) : 'x;
            if (v && x_ready) i++;
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = 'x;
    endtask

    task automatic drive_f(input int kind, input bit rnd, input int cnt);
        int j = 0;
        int cyc = 0;
        bit v;
        while (j < cnt && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            f_valid = v;
            f_data  = v ? fval(kind, j) : 'x;
            if (v && f_ready) j++;
        end
        @(negedge clk);
        f_valid = 1'b0;
        f_data  = 'x;
    endtask

    // Captures accepted outputs and counts hold violations while stalled.
    task automatic collect(input int nout, input bit rnd);
        int cyc = 0;
        bit pend = 1'b0;
        logic [25:0] pd = '0;
        ncap  = 0;
        nstab = 0;
        while (ncap < nout && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (pend && (y_valid !== 1'b1 || y_data !== pd)) nstab++;
            y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (y_valid === 1'b1) begin
                if (y_ready) begin
                    cap[ncap] = y_data;
                    ncap++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pd   = y_data;
                end
            end else begin
                pend = 1'b0;
            end
        end
        @(negedge clk);
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready: got %b expected 0", x_ready); end
        if (f_ready !== 1'b0) begin errors++; $display("FAIL reset_f_ready: got %b expected 0", f_ready); end
        if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        if (y_data !== 26'd0) begin errors++; $display("FAIL reset_y_data: got %0d expected 0", y_data); end
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (x_ready !== 1'b1) begin errors++; $display("FAIL post_reset_x_ready: got %b expected 1", x_ready); end
        if (f_ready !== 1'b1) begin errors++; $display("FAIL post_reset_f_ready: got %b expected 1", f_ready); end
    endtask

    task automatic test_back_to_back();
        fork
            begin drive_x(1, 1'b0, 112); drive_x(2, 1'b0, 112); end
            begin drive_f(1, 1'b0, 49);  drive_f(2, 1'b0, 49);  end
            collect(128, 1'b0);
        join
        checks++;
        if (ncap !== 128) begin errors++; $display("FAIL b2b_count: got %0d expected 128", ncap); end
        for (int k = 0; k < ncap; k++) begin
            checks++;
            if (cap[k] !== yexp(k < 64 ? 1 : 2, k % 64)) begin
                errors++;
                $display("FAIL b2b_y[%0d]: got %0d expected %0d", k, $signed(cap[k]), $signed(yexp(k < 64 ? 1 : 2, k % 64)));
            end
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (y_valid !== 1'b0) bad++;
        end
        checks += 3;
        if (bad !== 0) begin errors++; $display("FAIL idle_y_valid: got %0d high cycles expected 0", bad); end
        if (x_ready !== 1'b1) begin errors++; $display("FAIL idle_x_ready: got %b expected 1", x_ready); end
        if (f_ready !== 1'b1) begin errors++; $display("FAIL idle_f_ready: got %b expected 1", f_ready); end
    endtask

    task automatic test_backpressure();
        fork
            begin drive_x(1, 1'b1, 112); drive_x(2, 1'b1, 112); end
            begin drive_f(1, 1'b1, 49);  drive_f(2, 1'b1, 49);  end
            collect(128, 1'b1);
        join
        checks += 2;
        if (ncap !== 128) begin errors++; $display("FAIL bp_count: got %0d expected 128", ncap); end
        if (nstab !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", nstab); end
        for (int k = 0; k < ncap; k++) begin
            checks++;
            if (cap[k] !== yexp(k < 64 ? 1 : 2, k % 64)) begin
                errors++;
                $display("FAIL bp_y[%0d]: got %0d expected %0d", k, $signed(cap[k]), $signed(yexp(k < 64 ? 1 : 2, k % 64)));
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_output: got y_valid %b expected 0", y_valid); end
    endtask

    task automatic test_reset_mid();
        drive_x(2, 1'b0, 60);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (x_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_x_ready: got %b expected 0", x_ready); end
        reset = 1'b0;
        fork
            drive_x(1, 1'b0, 112);
            drive_f(1, 1'b0, 49);
            collect(64, 1'b0);
        join
        checks++;
        if (ncap !== 64) begin errors++; $display("FAIL mid_count: got %0d expected 64", ncap); end
        for (int k = 0; k < ncap; k++) begin
            checks++;
            if (cap[k] !== yexp(1, k)) begin
                errors++;
                $display("FAIL mid_y[%0d]: got %0d expected %0d", k, $signed(cap[k]), $signed(yexp(1, k)));
            end
        end
    endtask

    task automatic test_sign();
        fork
            begin drive_x(3, 1'b0, 112); drive_x(4, 1'b0, 112); end
            begin drive_f(3, 1'b0, 49);  drive_f(4, 1'b0, 49);  end
            collect(128, 1'b0);
        join
        checks++;
        if (ncap !== 128) begin errors++; $display("FAIL sign_count: got %0d expected 128", ncap); end
        for (int k = 0; k < ncap; k++) begin
            checks++;
            if (cap[k] !== yexp(k < 64 ? 3 : 4, k % 64)) begin
                errors++;
                $display("FAIL sign_y[%0d]: got %0d expected %0d", k, $signed(cap[k]), $signed(yexp(k < 64 ? 3 : 4, k % 64)));
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        x_valid = 1'b0;
        f_valid = 1'b0;
        y_ready = 1'b0;
        x_data  = '0;
        f_data  = '0;
        test_reset();
        test_back_to_back();
        test_idle();
        test_backpressure();
        test_reset_mid();
        test_sign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
